// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix store.
// Holds size defaults, load-select codes, Z FSM state type.
package matrix_pkg;

  localparam int M_DEF = 4;
  localparam int W_DEF = 32;

  localparam logic [1:0] LD_SEL_A = 2'd0;
  localparam logic [1:0] LD_SEL_B = 2'd1;

  typedef enum logic [1:0] {
    Z_IDLE     = 2'd0,
    Z_ACK      = 2'd1,
    Z_WAIT_LOW = 2'd2
  } z_state_e;

  function automatic logic idx_ok(
    input int idx,
    input int m
  );
    return (idx >= 0) && (idx < m);
  endfunction

endpackage

// File: rtl/matrix_bank.sv
// M x M bank of W-bit registers: one write port, NR comb read ports.
// Ports: clk, rst, zero (sync clear), we/wr_i/wr_j/wr_data, rd_i/rd_j/rd_data[NR].
module matrix_bank
  import matrix_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int M_LEN = (M > 1) ? $clog2(M) : 1,
  parameter int W     = W_DEF,
  parameter int NR    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     zero,
  input  logic                     we,
  input  logic [M_LEN-1:0]         wr_i,
  input  logic [M_LEN-1:0]         wr_j,
  input  logic [W-1:0]             wr_data,
  input  logic [NR-1:0][M_LEN-1:0] rd_i,
  input  logic [NR-1:0][M_LEN-1:0] rd_j,
  output logic [NR-1:0][W-1:0]     rd_data
);

  logic [M-1:0][M-1:0][W-1:0] mem_q;
  logic [M-1:0][M-1:0][W-1:0] mem_d;

  logic wr_ok;
  assign wr_ok = idx_ok(int'(wr_i), M) && idx_ok(int'(wr_j), M);

  always_comb begin
    mem_d = mem_q;
    if (zero) begin
      mem_d = '0;
    end else if (we && wr_ok) begin
      mem_d[wr_i][wr_j] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Addresses past M-1 (non power-of-two M) read as zero.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NR; r++) begin
      if (idx_ok(int'(rd_i[r]), M) && idx_ok(int'(rd_j[r]), M)) begin
        rd_data[r] = mem_q[rd_i[r]][rd_j[r]];
      end
    end
  end

endmodule

// File: rtl/matrix_store.sv
// Operand store (A, B) and result store (C) for a matrix multiplier.
// Ports: host load, A/B/C comb reads, Z result handshake, C readback, status.
module matrix_store
  import matrix_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int M_LEN = (M > 1) ? $clog2(M) : 1,
  parameter int W     = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld_valid,
  input  logic [1:0]       ld_sel,
  input  logic [M_LEN-1:0] ld_i,
  input  logic [M_LEN-1:0] ld_j,
  input  logic [W-1:0]     ld_data,
  input  logic [M_LEN-1:0] a_i,
  input  logic [M_LEN-1:0] a_j,
  output logic [W-1:0]     a_out,
  input  logic [M_LEN-1:0] b_i,
  input  logic [M_LEN-1:0] b_j,
  output logic [W-1:0]     b_out,
  input  logic [M_LEN-1:0] z_i,
  input  logic [M_LEN-1:0] z_j,
  output logic [W-1:0]     current_element,
  input  logic [W-1:0]     z_in,
  input  logic             z_stb,
  output logic             z_ack,
  input  logic             rd_en,
  input  logic [M_LEN-1:0] rd_i,
  input  logic [M_LEN-1:0] rd_j,
  output logic [W-1:0]     rd_data,
  output logic             rd_valid,
  output logic             all_written,
  output logic [15:0]      wr_count
);

  logic a_we;
  logic b_we;
  logic c_we;
  logic capture;

  logic [1:0][W-1:0] c_rd;

  z_state_e z_state_q;
  z_state_e z_state_d;
  logic     z_ack_q;
  logic     z_ack_d;

  logic [M-1:0][M-1:0] flags_q;
  logic [M-1:0][M-1:0] flags_d;
  logic [15:0]         wr_cnt_q;
  logic [15:0]         wr_cnt_d;
  logic [W-1:0]        rd_data_q;
  logic [W-1:0]        rd_data_d;
  logic                rd_valid_q;
  logic                rd_valid_d;

  assign a_we = ld_valid && (ld_sel == LD_SEL_A);
  assign b_we = ld_valid && (ld_sel == LD_SEL_B);

  assign capture = (z_state_q == Z_IDLE) && z_stb;
  // clr drops the write but the handshake still completes.
  assign c_we = capture && !clr;

  matrix_bank #(
    .M(M), .M_LEN(M_LEN), .W(W), .NR(1)
  ) u_bank_a (
    .clk     (clk),
    .rst     (rst),
    .zero    (1'b0),
    .we      (a_we),
    .wr_i    (ld_i),
    .wr_j    (ld_j),
    .wr_data (ld_data),
    .rd_i    (a_i),
    .rd_j    (a_j),
    .rd_data (a_out)
  );

  matrix_bank #(
    .M(M), .M_LEN(M_LEN), .W(W), .NR(1)
  ) u_bank_b (
    .clk     (clk),
    .rst     (rst),
    .zero    (1'b0),
    .we      (b_we),
    .wr_i    (ld_i),
    .wr_j    (ld_j),
    .wr_data (ld_data),
    .rd_i    (b_i),
    .rd_j    (b_j),
    .rd_data (b_out)
  );

  matrix_bank #(
    .M(M), .M_LEN(M_LEN), .W(W), .NR(2)
  ) u_bank_c (
    .clk     (clk),
    .rst     (rst),
    .zero    (clr),
    .we      (c_we),
    .wr_i    (z_i),
    .wr_j    (z_j),
    .wr_data (z_in),
    .rd_i    ({rd_i, z_i}),
    .rd_j    ({rd_j, z_j}),
    .rd_data (c_rd)
  );

  assign current_element = c_rd[0];

  always_comb begin
    z_state_d = z_state_q;
    unique case (z_state_q)
      Z_IDLE:     if (z_stb) z_state_d = Z_ACK;
      Z_ACK:      z_state_d = Z_WAIT_LOW;
      Z_WAIT_LOW: if (!z_stb) z_state_d = Z_IDLE;
      default:    z_state_d = Z_IDLE;
    endcase
    z_ack_d = (z_state_d == Z_ACK);
  end

  always_comb begin
    flags_d  = flags_q;
    wr_cnt_d = wr_cnt_q;
    if (clr) begin
      flags_d  = '0;
      wr_cnt_d = '0;
    end else if (c_we) begin
      if (idx_ok(int'(z_i), M) && idx_ok(int'(z_j), M)) begin
        flags_d[z_i][z_j] = 1'b1;
      end
      if (wr_cnt_q != 16'hFFFF) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end
    end
  end

  // Readback samples C before this edge's capture lands.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = c_rd[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_state_q  <= Z_IDLE;
      z_ack_q    <= 1'b0;
      flags_q    <= '0;
      wr_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      z_state_q  <= z_state_d;
      z_ack_q    <= z_ack_d;
      flags_q    <= flags_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign z_ack       = z_ack_q;
  assign all_written = &flags_q;
  assign wr_count    = wr_cnt_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_matrix_store.sv
// Self-checking bench for matrix_store (M=4, W=32).
// Table-driven loads, directed handshake corners, random ops vs model.
module tb_matrix_store;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        ld_valid;
  logic [1:0]  ld_sel;
  logic [1:0]  ld_i, ld_j;
  logic [31:0] ld_data;
  logic [1:0]  a_i, a_j, b_i, b_j, z_i, z_j, rd_i, rd_j;
  logic [31:0] a_out, b_out, current_element, z_in, rd_data;
  logic        z_stb, z_ack, rd_en, rd_valid, all_written;
  logic [15:0] wr_count;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] ra [4][4];
  logic [31:0] rb [4][4];
  logic [31:0] rc [4][4];
  bit          rf [4][4];
  int          rcnt;

  matrix_store dut (
    .clk(clk), .rst(rst), .clr(clr),
    .ld_valid(ld_valid), .ld_sel(ld_sel),
    .ld_i(ld_i), .ld_j(ld_j), .ld_data(ld_data),
    .a_i(a_i), .a_j(a_j), .a_out(a_out),
    .b_i(b_i), .b_j(b_j), .b_out(b_out),
    .z_i(z_i), .z_j(z_j), .current_element(current_element),
    .z_in(z_in), .z_stb(z_stb), .z_ack(z_ack),
    .rd_en(rd_en), .rd_i(rd_i), .rd_j(rd_j),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .all_written(all_written), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  i;
    logic [1:0]  j;
    logic [31:0] d;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vt [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic model_all();
    logic r = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r &= rf[i][j];
    return r;
  endfunction

  task automatic model_clear_c();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        rc[i][j] = '0;
        rf[i][j] = 1'b0;
      end
    rcnt = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ra[i][j] = '0;
        rb[i][j] = '0;
      end
    model_clear_c();
  endtask

  task automatic model_zw(input logic [1:0] i, input logic [1:0] j,
                          input logic [31:0] d);
    rc[i][j] = d;
    rf[i][j] = 1'b1;
    if (rcnt < 65535) rcnt++;
  endtask

  task automatic load(input logic [1:0] sel, input logic [1:0] i,
                      input logic [1:0] j, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_sel = sel;
    ld_i = i;
    ld_j = j;
    ld_data = d;
    tick();
    ld_valid = 1'b0;
    if (sel == 2'd0) ra[i][j] = d;
    if (sel == 2'd1) rb[i][j] = d;
  endtask

  // Full Z handshake; z_stb stays high for 'hold' cycles after ack.
  task automatic z_write(input logic [1:0] i, input logic [1:0] j,
                         input logic [31:0] d, input int hold);
    int cyc = 0;
    z_i = i;
    z_j = j;
    z_in = d;
    z_stb = 1'b1;
    do begin
      tick();
      cyc++;
    end while (!z_ack && cyc < 8);
    check("z_ack_latency", 32'(cyc), 32'd1);
    model_zw(i, j, d);
    check("z_capture", current_element, d);
    check("z_wr_count", 32'(wr_count), 32'(rcnt));
    for (int h = 0; h < hold; h++) begin
      tick();
      check("z_ack_once", 32'(z_ack), 32'd0);
      check("z_no_recapture", 32'(wr_count), 32'(rcnt));
    end
    z_stb = 1'b0;
    tick();
  endtask

  initial begin
    logic [1:0]  ri, rj, si, sj;
    logic [31:0] rd;
    int          op;

    vt[0] = '{2'd0, 2'd1, 2'd2, 32'h40400000, 32'h40400000, 32'h0};
    vt[1] = '{2'd1, 2'd1, 2'd2, 32'h3F800000, 32'h40400000, 32'h3F800000};
    vt[2] = '{2'd2, 2'd1, 2'd2, 32'hDEADBEEF, 32'h40400000, 32'h3F800000};
    vt[3] = '{2'd3, 2'd1, 2'd2, 32'hCAFEF00D, 32'h40400000, 32'h3F800000};
    vt[4] = '{2'd0, 2'd3, 2'd3, 32'hC0000000, 32'hC0000000, 32'h0};
    vt[5] = '{2'd1, 2'd0, 2'd0, 32'h12345678, 32'h0, 32'h12345678};

    rst = 1'b1; clr = 1'b0; ld_valid = 1'b0; ld_sel = '0;
    ld_i = '0; ld_j = '0; ld_data = '0;
    a_i = '0; a_j = '0; b_i = '0; b_j = '0;
    z_i = '0; z_j = '0; z_in = '0; z_stb = 1'b0;
    rd_en = 1'b0; rd_i = '0; rd_j = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_z_ack", 32'(z_ack), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_all_written", 32'(all_written), 32'd0);
    check("rst_a_out", a_out, 32'd0);

    // Load table
    for (int k = 0; k < 6; k++) begin
      load(vt[k].sel, vt[k].i, vt[k].j, vt[k].d);
      a_i = vt[k].i; a_j = vt[k].j;
      b_i = vt[k].i; b_j = vt[k].j;
      z_i = vt[k].i; z_j = vt[k].j;
      #1;
      check($sformatf("tbl%0d_a", k), a_out, vt[k].ea);
      check($sformatf("tbl%0d_b", k), b_out, vt[k].eb);
      check($sformatf("tbl%0d_c", k), current_element, 32'd0);
    end

    // Single write held high after ack
    z_write(2'd2, 2'd3, 32'h41200000, 3);

    // Host load and capture on the same edge
    ld_valid = 1'b1; ld_sel = 2'd0; ld_i = 2'd0; ld_j = 2'd1;
    ld_data = 32'hAAAA5555;
    z_i = 2'd1; z_j = 2'd0; z_in = 32'h5555AAAA; z_stb = 1'b1;
    tick();
    ld_valid = 1'b0;
    ra[0][1] = 32'hAAAA5555;
    model_zw(2'd1, 2'd0, 32'h5555AAAA);
    a_i = 2'd0; a_j = 2'd1;
    #1;
    check("dual_a", a_out, 32'hAAAA5555);
    check("dual_c", current_element, 32'h5555AAAA);
    check("dual_ack", 32'(z_ack), 32'd1);
    z_stb = 1'b0;
    tick();
    tick();

    // Fill all 16 then clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear_c();
    for (int k = 0; k < 16; k++) begin
      z_write(2'(k / 4), 2'(k % 4), 32'h100 + 32'(k), 1);
      check("fill_all_written", 32'(all_written), 32'(k == 15));
    end
    check("fill_count", 32'(wr_count), 32'd16);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear_c();
    z_i = 2'd3; z_j = 2'd3;
    #1;
    check("clr_all_written", 32'(all_written), 32'd0);
    check("clr_wr_count", 32'(wr_count), 32'd0);
    check("clr_cur", current_element, 32'd0);

    // clr and capture on the same edge
    z_i = 2'd1; z_j = 2'd1; z_in = 32'h55; z_stb = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    check("clrcap_ack", 32'(z_ack), 32'd1);
    check("clrcap_c", current_element, 32'd0);
    check("clrcap_count", 32'(wr_count), 32'd0);
    tick();
    check("clrcap_ack_low", 32'(z_ack), 32'd0);
    z_stb = 1'b0;
    tick();

    // Read-before-write on same address
    z_write(2'd0, 2'd0, 32'h11111111, 1);
    rd_en = 1'b1; rd_i = 2'd0; rd_j = 2'd0;
    z_i = 2'd0; z_j = 2'd0; z_in = 32'h3F800000; z_stb = 1'b1;
    tick();
    check("rbw_old", rd_data, 32'h11111111);
    check("rbw_valid", 32'(rd_valid), 32'd1);
    check("rbw_ack", 32'(z_ack), 32'd1);
    model_zw(2'd0, 2'd0, 32'h3F800000);
    tick();
    check("rbw_new", rd_data, 32'h3F800000);
    z_stb = 1'b0; rd_en = 1'b0;
    tick();
    check("rd_valid_low", 32'(rd_valid), 32'd0);

    // Reset in the middle of a handshake
    z_i = 2'd2; z_j = 2'd2; z_in = 32'h77; z_stb = 1'b1;
    tick();
    check("midrst_ack", 32'(z_ack), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    a_i = 2'd0; a_j = 2'd1; b_i = 2'd1; b_j = 2'd2;
    #1;
    check("midrst_ack_drop", 32'(z_ack), 32'd0);
    check("midrst_a", a_out, 32'd0);
    check("midrst_b", b_out, 32'd0);
    check("midrst_c", current_element, 32'd0);
    check("midrst_count", 32'(wr_count), 32'd0);
    tick();
    model_zw(2'd2, 2'd2, 32'h77);
    check("midrst_recap_ack", 32'(z_ack), 32'd1);
    check("midrst_recap_c", current_element, 32'h77);
    check("midrst_recap_cnt", 32'(wr_count), 32'd1);
    tick();
    z_stb = 1'b0;
    tick();

    // Random operations against the model
    for (int n = 0; n < 200; n++) begin
      op = int'($urandom_range(0, 9));
      ri = 2'($urandom_range(0, 3));
      rj = 2'($urandom_range(0, 3));
      rd = $urandom;
      if (op <= 2) begin
        load(2'($urandom_range(0, 3)), ri, rj, rd);
        si = 2'($urandom_range(0, 3));
        sj = 2'($urandom_range(0, 3));
        a_i = ri; a_j = rj; b_i = si; b_j = sj;
        #1;
        check("rnd_a", a_out, ra[ri][rj]);
        check("rnd_b", b_out, rb[si][sj]);
      end else if (op <= 5) begin
        z_write(ri, rj, rd, int'($urandom_range(1, 3)));
      end else if (op <= 7) begin
        rd_en = 1'b1; rd_i = ri; rd_j = rj;
        tick();
        rd_en = 1'b0;
        check("rnd_rd", rd_data, rc[ri][rj]);
        check("rnd_rd_valid", 32'(rd_valid), 32'd1);
      end else if (op == 8) begin
        z_i = ri; z_j = rj;
        #1;
        check("rnd_cur", current_element, rc[ri][rj]);
        check("rnd_all", 32'(all_written), 32'(model_all()));
        check("rnd_cnt", 32'(wr_count), 32'(rcnt));
      end else begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear_c();
        #1;
        check("rnd_clr_cnt", 32'(wr_count), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
